// File: rtl/bcd_entry_writer_pkg.sv
// Shared types and constants for the BCD entry writer.
// Optional AUTO_SEND_EN: auto-send once four digits are held.
package kpn_entry_pkg;

  localparam int TOKEN_W = 16;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SPACE,
    WRITE,
    CLEAR
  } state_t;

  localparam state_t STATE_RST = IDLE;
  localparam logic [TOKEN_W-1:0] TOKEN_RST = '0;
  localparam logic [2:0] COUNT_RST = 3'd0;

  function automatic logic is_bcd(input logic [3:0] v);
    return v <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_entry_writer_if.sv
// FIFO write port: producer drives wr/data_out,
// FIFO returns full.
interface bcd_entry_writer_if;
  import kpn_entry_pkg::*;

  logic wr;
  logic [TOKEN_W-1:0] data_out;
  logic full;

  modport master (
    output wr,
    output data_out,
    input  full
  );

  modport slave (
    input  wr,
    input  data_out,
    output full
  );

endinterface

// File: rtl/bcd_entry_writer_debouncer.sv
// Button conditioning: 2-flop sync, stability counter,
// and a one-cycle press pulse on the accepted rising level.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic level;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync  <= 2'b00;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // enough consecutive differing samples: accept
        cnt   <= '0;
        level <= sync[1];
        press <= sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/bcd_entry_writer.sv
// Operator BCD entry to 16-bit FIFO token writer.
// Optional AUTO_SEND_EN: fourth valid digit triggers send.
module bcd_entry_writer
  import kpn_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DIGITS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] switches,
  input  logic       load_btn,
  input  logic       send_btn,
  bcd_entry_writer_if.master fifo,
  output logic [2:0] digit_count,
  output logic       busy,
  output logic       bad_digit
);

  localparam logic [2:0] MAX_CNT = 3'(DIGITS);

  logic load_ev;
  logic send_ev;

  state_t state, state_n;
  logic [TOKEN_W-1:0] entry, entry_n;
  logic [TOKEN_W-1:0] data, data_n;
  logic [2:0] count, count_n;
  logic bad, bad_n;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_load_db (
    .clock(clock),
    .reset(reset),
    .btn  (load_btn),
    .press(load_ev)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_send_db (
    .clock(clock),
    .reset(reset),
    .btn  (send_btn),
    .press(send_ev)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= STATE_RST;
      entry <= TOKEN_RST;
      data  <= TOKEN_RST;
      count <= COUNT_RST;
      bad   <= 1'b0;
    end else begin
      state <= state_n;
      entry <= entry_n;
      data  <= data_n;
      count <= count_n;
      bad   <= bad_n;
    end
  end

  always_comb begin
    state_n = state;
    entry_n = entry;
    data_n  = data;
    count_n = count;
    bad_n   = bad;
    unique case (state)
      IDLE: begin
        // load lands first so a same-cycle send sees it
        if (load_ev) begin
          if (is_bcd(switches)) begin
            entry_n = {entry[TOKEN_W-5:0], switches};
            if (count < MAX_CNT)
              count_n = count + 3'd1;
`ifdef AUTO_SEND_EN
            if (count == MAX_CNT - 3'd1)
              state_n = WAIT_SPACE;
`endif
          end else begin
            bad_n = 1'b1;
          end
        end
        if (send_ev && count_n != 3'd0)
          state_n = WAIT_SPACE;
      end
      WAIT_SPACE: begin
        if (!fifo.full) begin
          state_n = WRITE;
          data_n  = entry;
        end
      end
      WRITE: begin
        state_n = CLEAR;
      end
      CLEAR: begin
        entry_n = TOKEN_RST;
        count_n = COUNT_RST;
        bad_n   = 1'b0;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign fifo.wr       = (state == WRITE);
  assign fifo.data_out = data;
  assign digit_count   = count;
  assign busy          = (state != IDLE);
  assign bad_digit     = bad;

endmodule

// File: tb/tb_bcd_entry_writer.sv
// Directed bench for bcd_entry_writer, DEBOUNCE_CYCLES=4.
// Define AUTO_SEND_EN to exercise the auto-send path.
module tb_bcd_entry_writer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [3:0] switches = 4'd0;
  logic load_btn = 1'b0;
  logic send_btn = 1'b0;
  logic [2:0] digit_count;
  logic busy;
  logic bad_digit;

  int vectors = 0;
  int miscompares = 0;
  int wr_count = 0;
  logic [15:0] last_data = 16'h0;

  bcd_entry_writer_if fifo ();

  bcd_entry_writer #(
    .DEBOUNCE_CYCLES(4),
    .DIGITS(4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .switches   (switches),
    .load_btn   (load_btn),
    .send_btn   (send_btn),
    .fifo       (fifo.master),
    .digit_count(digit_count),
    .busy       (busy),
    .bad_digit  (bad_digit)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (fifo.wr === 1'b1) begin
      wr_count++;
      last_data = fifo.data_out;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_digit(input logic [3:0] d);
    switches = d;
    load_btn = 1'b1;
    tick(8);
    load_btn = 1'b0;
    tick(8);
  endtask

  task automatic send_token();
    send_btn = 1'b1;
    tick(8);
    send_btn = 1'b0;
    tick(8);
  endtask

  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 30) begin
      tick(1);
      n++;
    end
    check(tag, busy, 1'b1);
  endtask

  int base;

  initial begin
    fifo.full = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_wr", fifo.wr, 1'b0);
    check("rst_data", fifo.data_out, 16'h0000);
    check("rst_count", digit_count, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_bad", bad_digit, 1'b0);

    // 1,2,3,4 then send
    load_digit(4'd1);
    load_digit(4'd2);
    load_digit(4'd3);
    load_digit(4'd4);
    check("cnt4", digit_count, 3'd4);
    check("idle_busy", busy, 1'b0);
    base = wr_count;
    send_token();
    check("t1_pulses", wr_count - base, 1);
    check("t1_data", last_data, 16'h1234);
    check("t1_count", digit_count, 3'd0);
    check("t1_busy", busy, 1'b0);
    check("t1_hold", fifo.data_out, 16'h1234);

    // 7,8 with exact latency check
    load_digit(4'd7);
    load_digit(4'd8);
    check("cnt2", digit_count, 3'd2);
    send_btn = 1'b1;
    wait_busy("t2_busy");
    check("t2_wait_wr", fifo.wr, 1'b0);
    tick(1);
    check("t2_wr", fifo.wr, 1'b1);
    check("t2_data", fifo.data_out, 16'h0078);
    tick(1);
    check("t2_wr_drop", fifo.wr, 1'b0);
    send_btn = 1'b0;
    tick(10);
    check("t2_idle", busy, 1'b0);

    // five digits: oldest shifts out
    load_digit(4'd1);
    load_digit(4'd2);
    load_digit(4'd3);
    load_digit(4'd4);
    load_digit(4'd5);
    check("cnt_sat", digit_count, 3'd4);
    base = wr_count;
    send_token();
    check("t3_pulses", wr_count - base, 1);
    check("t3_data", last_data, 16'h2345);

    // invalid digit
    load_digit(4'hA);
    check("bad_set", bad_digit, 1'b1);
    check("bad_cnt", digit_count, 3'd0);
    check("bad_nobusy", busy, 1'b0);
    load_digit(4'd9);
    load_digit(4'd9);
    check("bad_sticky", bad_digit, 1'b1);
    base = wr_count;
    send_token();
    check("t4_data", last_data, 16'h0099);
    check("t4_pulses", wr_count - base, 1);
    check("bad_clr", bad_digit, 1'b0);

    // send with no digits is ignored
    base = wr_count;
    send_token();
    check("empty_send", wr_count - base, 0);

    // full backpressure
    load_digit(4'd4);
    load_digit(4'd2);
    fifo.full = 1'b1;
    send_btn = 1'b1;
    wait_busy("bp_busy");
    base = wr_count;
    tick(10);
    send_btn = 1'b0;
    tick(10);
    check("bp_nowr", wr_count - base, 0);
    check("bp_busy_hold", busy, 1'b1);
    fifo.full = 1'b0;
    tick(1);
    check("bp_wr", fifo.wr, 1'b1);
    check("bp_data", fifo.data_out, 16'h0042);
    tick(1);
    check("bp_wr_drop", fifo.wr, 1'b0);
    tick(6);
    check("bp_idle", busy, 1'b0);

    // two-cycle glitch is rejected
    switches = 4'd5;
    load_btn = 1'b1;
    tick(2);
    load_btn = 1'b0;
    tick(10);
    check("glitch_cnt", digit_count, 3'd0);

    // reset while waiting for space
    load_digit(4'd6);
    load_digit(4'hB);
    fifo.full = 1'b1;
    send_btn = 1'b1;
    wait_busy("rw_busy");
    send_btn = 1'b0;
    tick(8);
    base = wr_count;
    reset = 1'b1;
    tick(1);
    check("rw_busy0", busy, 1'b0);
    check("rw_cnt0", digit_count, 3'd0);
    check("rw_bad0", bad_digit, 1'b0);
    check("rw_data0", fifo.data_out, 16'h0000);
    reset = 1'b0;
    fifo.full = 1'b0;
    tick(12);
    check("rw_nowr", wr_count - base, 0);
    check("rw_idle", busy, 1'b0);

`ifdef AUTO_SEND_EN
    base = wr_count;
    load_digit(4'd5);
    load_digit(4'd6);
    load_digit(4'd7);
    load_digit(4'd8);
    tick(4);
    check("auto_pulses", wr_count - base, 1);
    check("auto_data", last_data, 16'h5678);
    check("auto_cnt", digit_count, 3'd0);
`else
    base = wr_count;
    load_digit(4'd5);
    load_digit(4'd6);
    load_digit(4'd7);
    load_digit(4'd8);
    tick(4);
    check("noauto_pulses", wr_count - base, 0);
    check("noauto_cnt", digit_count, 3'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
